// File: rtl/wb_write_arbiter_if.sv
// Writeback arbiter bus: ALU/load producers in, register-file write port and
// decode hazard queries out.
interface wb_write_arbiter_if #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned AW    = 4,
  parameter int unsigned DW    = 32
);
  localparam int unsigned OW = $clog2(DEPTH) + 1;

  logic          alu_valid;
  logic [AW-1:0] alu_rd;
  logic [DW-1:0] alu_result;
  logic          alu_ready;
  logic          ld_valid;
  logic [AW-1:0] ld_rd;
  logic [DW-1:0] ld_data;
  logic          wr_en;
  logic [AW-1:0] write_addr;
  logic [DW-1:0] write_data;
  logic [AW-1:0] chk_addr1;
  logic [AW-1:0] chk_addr2;
  logic          hazard1;
  logic          hazard2;
  logic [OW-1:0] occupancy;

  modport master (
    output alu_valid, alu_rd, alu_result, ld_valid, ld_rd, ld_data, chk_addr1, chk_addr2,
    input  alu_ready, wr_en, write_addr, write_data, hazard1, hazard2, occupancy
  );

  modport slave (
    input  alu_valid, alu_rd, alu_result, ld_valid, ld_rd, ld_data, chk_addr1, chk_addr2,
    output alu_ready, wr_en, write_addr, write_data, hazard1, hazard2, occupancy
  );
endinterface

// File: rtl/wb_write_arbiter.sv
// Merges load returns (absolute priority) and ALU results into the single
// register-file write port; losing ALU results wait in an in-order FIFO.
module wb_write_arbiter #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned AW    = 4,
  parameter int unsigned DW    = 32
) (
  input logic               clk,
  input logic               reset_n,
  wb_write_arbiter_if.slave bus
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned OW = PW + 1;

  typedef struct packed {
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } entry_t;

  entry_t        mem [DEPTH];
  entry_t        head;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [OW-1:0] count;
  logic          ready;
  logic          accept;
  logic          empty;
  logic          push;
  logic          pop;
  logic          bypass;
  logic          wr_en_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] data_q;
  logic          hz1;
  logic          hz2;

  assign ready  = count < OW'(DEPTH);
  assign empty  = (count == '0);
  assign accept = bus.alu_valid && ready;
  assign pop    = !bus.ld_valid && !empty;
  assign push   = accept && (bus.ld_valid || !empty);
  assign bypass = accept && !bus.ld_valid && empty;
  assign head   = mem[rd_ptr];

  assign bus.alu_ready  = ready;
  assign bus.occupancy  = count;
  assign bus.wr_en      = wr_en_q;
  assign bus.write_addr = addr_q;
  assign bus.write_data = data_q;
  assign bus.hazard1    = hz1;
  assign bus.hazard2    = hz2;

  // FIFO storage carries no reset; validity comes from count alone.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= entry_t'{rd: bus.alu_rd, data: bus.alu_result};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      count <= count + OW'(1);
      else if (pop && !push) count <= count - OW'(1);
    end
  end

  // Output stage: load, then FIFO head, then bypassed ALU result.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_en_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else if (bus.ld_valid) begin
      wr_en_q <= 1'b1;
      addr_q  <= bus.ld_rd;
      data_q  <= bus.ld_data;
    end else if (pop) begin
      wr_en_q <= 1'b1;
      addr_q  <= head.rd;
      data_q  <= head.data;
    end else if (bypass) begin
      wr_en_q <= 1'b1;
      addr_q  <= bus.alu_rd;
      data_q  <= bus.alu_result;
    end else begin
      wr_en_q <= 1'b0;
    end
  end

  // The output stage is still pending until the register file sees it.
  always_comb begin
    hz1 = wr_en_q && (addr_q == bus.chk_addr1);
    hz2 = wr_en_q && (addr_q == bus.chk_addr2);
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (OW'(i) < count) begin
        if (mem[PW'(rd_ptr + PW'(i))].rd == bus.chk_addr1) hz1 = 1'b1;
        if (mem[PW'(rd_ptr + PW'(i))].rd == bus.chk_addr2) hz2 = 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_wb_write_arbiter.sv
// Self-checking bench for wb_write_arbiter: per-source expected-write queues
// plus directed checks of handshake, occupancy, hazards and reset.
module tb_wb_write_arbiter;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned AW    = 4;
  localparam int unsigned DW    = 32;
  localparam int unsigned OW    = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic reset_n;
  logic ld_prev;
  wr_t  ld_exp[$];
  wr_t  alu_exp[$];
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  wb_write_arbiter_if #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) bus ();

  wb_write_arbiter #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of stimulus; expectations are queued as they are presented.
  task automatic step(input logic lv, input logic [AW-1:0] lrd, input logic [DW-1:0] ldat,
                      input logic av, input logic [AW-1:0] ard, input logic [DW-1:0] adat,
                      output logic acc);
    bus.ld_valid   = lv;
    bus.ld_rd      = lrd;
    bus.ld_data    = ldat;
    bus.alu_valid  = av;
    bus.alu_rd     = ard;
    bus.alu_result = adat;
    acc = av && bus.alu_ready;
    if (lv)  ld_exp.push_back(wr_t'{rd: lrd, data: ldat});
    if (acc) alu_exp.push_back(wr_t'{rd: ard, data: adat});
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    logic a;
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, '0, '0, a);
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) ld_prev <= 1'b0;
    else          ld_prev <= bus.ld_valid;
  end

  // Writes following a load cycle must be that load; all others come from the ALU queue.
  always @(negedge clk) begin
    wr_t e;
    if (reset_n) begin
      if (ld_prev) check("ld_next_cycle_wr_en", bus.wr_en, 1);
      if (bus.wr_en === 1'b1) begin
        if (ld_prev) begin
          if (ld_exp.size() == 0) check("unexpected_ld_write", 1, 0);
          else begin
            e = ld_exp.pop_front();
            check("ld_write_addr", bus.write_addr, e.rd);
            check("ld_write_data", bus.write_data, e.data);
          end
        end else begin
          if (alu_exp.size() == 0) check("unexpected_alu_write", 1, 0);
          else begin
            e = alu_exp.pop_front();
            check("alu_write_addr", bus.write_addr, e.rd);
            check("alu_write_data", bus.write_data, e.data);
          end
        end
      end
      check("occupancy_bound", bus.occupancy <= OW'(DEPTH), 1);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic          a;
    logic [OW-1:0] occ_b;
    bit            done;

    reset_n        = 1'b0;
    bus.alu_valid  = 1'b0;
    bus.alu_rd     = '0;
    bus.alu_result = '0;
    bus.ld_valid   = 1'b0;
    bus.ld_rd      = '0;
    bus.ld_data    = '0;
    bus.chk_addr1  = '0;
    bus.chk_addr2  = '0;
    #1;
    check("rst_wr_en", bus.wr_en, 0);
    check("rst_write_addr", bus.write_addr, 0);
    check("rst_write_data", bus.write_data, 0);
    check("rst_occupancy", bus.occupancy, 0);
    check("rst_alu_ready", bus.alu_ready, 1);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    idle(1);

    // Single ALU result bypasses the FIFO
    step(1'b0, '0, '0, 1'b1, 4'd3, 32'h0000_00AA, a);
    check("t2_accept", a, 1);
    check("t2_wr_en", bus.wr_en, 1);
    check("t2_write_addr", bus.write_addr, 3);
    check("t2_write_data", bus.write_data, 32'hAA);
    check("t2_occupancy", bus.occupancy, 0);
    idle(1);
    check("t2_idle_wr_en", bus.wr_en, 0);
    check("t2_hold_addr", bus.write_addr, 3);
    check("t2_hold_data", bus.write_data, 32'hAA);

    // Load and ALU collide: load first, ALU the cycle after
    step(1'b1, 4'd5, 32'hFFFF_FFFF, 1'b1, 4'd7, 32'h1, a);
    check("t3_accept", a, 1);
    check("t3_c1_addr", bus.write_addr, 5);
    check("t3_c1_data", bus.write_data, 32'hFFFF_FFFF);
    check("t3_c1_occ", bus.occupancy, 1);
    idle(1);
    check("t3_c2_wr_en", bus.wr_en, 1);
    check("t3_c2_addr", bus.write_addr, 7);
    check("t3_c2_data", bus.write_data, 32'h1);
    check("t3_c2_occ", bus.occupancy, 0);
    idle(1);

    // Loads for 3 cycles fill the FIFO; third ALU result waits upstream
    step(1'b1, 4'd8, 32'h100, 1'b1, 4'd1, 32'h11, a);
    check("t4_acc1", a, 1);
    step(1'b1, 4'd9, 32'h101, 1'b1, 4'd2, 32'h22, a);
    check("t4_acc2", a, 1);
    step(1'b1, 4'd10, 32'h102, 1'b1, 4'd3, 32'h33, a);
    check("t4_acc3_blocked", a, 0);
    check("t4_full_occ", bus.occupancy, 2);
    check("t4_full_ready", bus.alu_ready, 0);
    step(1'b0, '0, '0, 1'b1, 4'd3, 32'h33, a);
    check("t4_still_blocked", a, 0);
    check("t4_r1_addr", bus.write_addr, 1);
    check("t4_r1_occ", bus.occupancy, 1);
    step(1'b0, '0, '0, 1'b1, 4'd3, 32'h33, a);
    check("t4_acc3", a, 1);
    check("t4_r2_addr", bus.write_addr, 2);
    check("t4_pushpop_occ", bus.occupancy, 1);
    idle(1);
    check("t4_r3_wr_en", bus.wr_en, 1);
    check("t4_r3_addr", bus.write_addr, 3);
    check("t4_r3_occ", bus.occupancy, 0);
    idle(1);

    // Full FIFO, no load: ALU result rd=4 enters via a simultaneous push/pop
    step(1'b1, 4'd14, 32'h200, 1'b1, 4'd1, 32'h1, a);
    step(1'b1, 4'd15, 32'h201, 1'b1, 4'd2, 32'h2, a);
    check("t5_full_occ", bus.occupancy, 2);
    check("t5_full_ready", bus.alu_ready, 0);
    done = 1'b0;
    for (int c = 0; c < 4 && !done; c++) begin
      occ_b = bus.occupancy;
      step(1'b0, '0, '0, 1'b1, 4'd4, 32'h4, a);
      if (a) begin
        done = 1'b1;
        check("t5_pushpop_occ", bus.occupancy, occ_b);
      end
    end
    check("t5_accepted_in_budget", done, 1);
    idle(3);

    // Hazard tracking through FIFO and output stage
    bus.chk_addr1 = 4'd9;
    bus.chk_addr2 = 4'd15;
    step(1'b1, 4'd2, 32'h2, 1'b1, 4'd9, 32'h99, a);
    check("t6_hz1_fifo", bus.hazard1, 1);
    check("t6_hz2_none", bus.hazard2, 0);
    bus.chk_addr2 = 4'd2;
    #1;
    check("t6_hz2_outstage", bus.hazard2, 1);
    bus.chk_addr2 = 4'd15;
    step(1'b1, 4'd3, 32'h3, 1'b0, '0, '0, a);
    check("t6_hz1_held", bus.hazard1, 1);
    check("t6_hz2_still_none", bus.hazard2, 0);
    idle(1);
    check("t6_r9_addr", bus.write_addr, 9);
    check("t6_r9_occ", bus.occupancy, 0);
    check("t6_hz1_outstage", bus.hazard1, 1);
    idle(1);
    check("t6_hz1_cleared", bus.hazard1, 0);
    step(1'b0, '0, '0, 1'b1, 4'd15, 32'hF, a);
    bus.chk_addr2 = 4'd15;
    #1;
    check("t6_hz2_r15", bus.hazard2, 1);
    idle(2);

    // Asynchronous reset with two entries buffered discards everything
    step(1'b1, 4'd10, 32'h300, 1'b1, 4'd12, 32'hC, a);
    step(1'b1, 4'd11, 32'h301, 1'b1, 4'd13, 32'hD, a);
    check("t1_pre_occ", bus.occupancy, 2);
    bus.ld_valid  = 1'b0;
    bus.alu_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    check("t1_wr_en", bus.wr_en, 0);
    check("t1_write_addr", bus.write_addr, 0);
    check("t1_write_data", bus.write_data, 0);
    check("t1_occupancy", bus.occupancy, 0);
    check("t1_alu_ready", bus.alu_ready, 1);
    ld_exp.delete();
    alu_exp.delete();
    idle(2);
    reset_n = 1'b1;
    bus.chk_addr1 = 4'd12;
    idle(3);
    check("t1_post_wr_en", bus.wr_en, 0);
    check("t1_post_occ", bus.occupancy, 0);
    check("t1_post_hazard", bus.hazard1, 0);

    for (int c = 0; c < 10 && (ld_exp.size() != 0 || alu_exp.size() != 0); c++) idle(1);
    check("drain_ld_queue", ld_exp.size(), 0);
    check("drain_alu_queue", alu_exp.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
